ic_number_entry: RTL

//  Operator front end of the IC tester: debounces the board push-buttons and accepts up to 4 decimal digits from SW[3:0].

---
 rtl/ic_tester_pkg.sv | 44 ++++
 rtl/ic_number_entry_if.sv | 45 ++++
 rtl/key_debounce.sv | 45 ++++
 rtl/ic_number_entry.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/ic_tester_pkg.sv
// Shared types and 7-segment constants for the IC tester operator front end.
// Active-low segment order is {g,f,e,d,c,b,a}.
package ic_tester_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    READ  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0011000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] bcd_to_seg(
    input logic [3:0] bcd
  );
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/ic_number_entry_if.sv
// Operator-side bundle: digit switch, raw keys, displays and confirm strobe.
// master = operator/board side, slave = number-entry block.
interface ic_number_entry_if;

  logic [3:0] sw_digit;
  logic       key_enter_n;
  logic       key_read_n;
  logic       key_clear_n;
  logic [6:0] HEX0;
  logic [6:0] HEX1;
  logic [6:0] HEX2;
  logic [6:0] HEX3;
  logic       ic_read;
  logic [2:0] digit_count;
  logic       entry_error;

  modport master (
    output sw_digit,
    output key_enter_n,
    output key_read_n,
    output key_clear_n,
    input  HEX0,
    input  HEX1,
    input  HEX2,
    input  HEX3,
    input  ic_read,
    input  digit_count,
    input  entry_error
  );

  modport slave (
    input  sw_digit,
    input  key_enter_n,
    input  key_read_n,
    input  key_clear_n,
    output HEX0,
    output HEX1,
    output HEX2,
    output HEX3,
    output ic_read,
    output digit_count,
    output entry_error
  );

endinterface

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stable-level counter,
// and a single-cycle strobe on the accepted press (1->0) edge.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  // Counter only runs while the synchronised input disagrees with level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      level   <= 1'b1;
      level_d <= 1'b1;
      cnt     <= '0;
    end else begin
      sync1   <= key_n;
      sync2   <= sync1;
      level_d <= level;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = level_d & ~level;

endmodule

// File: rtl/ic_number_entry.sv
// IC tester number entry: up to 4 BCD digits, 7-seg display, confirm strobe.
// Define BLANK_LEADING_ZERO_EN to blank positions not yet entered.
import ic_tester_pkg::*;

module ic_number_entry #(
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int READ_PULSE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  ic_number_entry_if.slave   bus
);

  localparam int PW = $clog2(READ_PULSE_CYCLES + 1);

`ifdef BLANK_LEADING_ZERO_EN
  localparam logic [6:0] HEX_EMPTY = SEG_BLANK;
`else
  localparam logic [6:0] HEX_EMPTY = SEG_0;
`endif

  logic en_ev;
  logic rd_ev;
  logic clr_ev;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .clk   (clk),
    .reset (reset),
    .key_n (bus.key_enter_n),
    .press (en_ev)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_read (
    .clk   (clk),
    .reset (reset),
    .key_n (bus.key_read_n),
    .press (rd_ev)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clk   (clk),
    .reset (reset),
    .key_n (bus.key_clear_n),
    .press (clr_ev)
  );

  state_t             state_q;
  state_t             state_d;
  logic [3:0][3:0]    dig_q;
  logic [3:0][3:0]    dig_d;
  logic [2:0]         cnt_q;
  logic [2:0]         cnt_d;
  logic [PW-1:0]      pc_q;
  logic [PW-1:0]      pc_d;
  logic               rd_q;
  logic               err_q;
  logic               err_d;
  logic [3:0][6:0]    hex_q;
  logic [3:0][6:0]    hex_d;

  // Clear outranks read, read outranks enter
  always_comb begin
    state_d = state_q;
    dig_d   = dig_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    err_d   = 1'b0;
    if (clr_ev) begin
      state_d = IDLE;
      dig_d   = '0;
      cnt_d   = '0;
      pc_d    = '0;
    end else begin
      unique case (state_q)
        IDLE, ENTRY: begin
          if (rd_ev) begin
            if (state_q == ENTRY) begin
              state_d = READ;
              pc_d    = '0;
            end else begin
              err_d = 1'b1;
            end
          end else if (en_ev) begin
            if (bus.sw_digit <= 4'd9) begin
              dig_d   = {dig_q[2:0], bus.sw_digit};
              state_d = ENTRY;
              if (cnt_q != 3'd4)
                cnt_d = cnt_q + 3'd1;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        READ: begin
          if (pc_q == PW'(READ_PULSE_CYCLES - 1))
            state_d = HOLD;
          else
            pc_d = pc_q + 1'b1;
        end
        HOLD: begin
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    hex_d = '0;
    for (int i = 0; i < 4; i++) begin
      hex_d[i] = bcd_to_seg(dig_q[i]);
`ifdef BLANK_LEADING_ZERO_EN
      if (3'(i) >= cnt_q)
        hex_d[i] = SEG_BLANK;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      dig_q   <= '0;
      cnt_q   <= '0;
      pc_q    <= '0;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
      hex_q   <= {4{HEX_EMPTY}};
    end else begin
      state_q <= state_d;
      dig_q   <= dig_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      rd_q    <= (state_d == READ);
      err_q   <= err_d;
      hex_q   <= hex_d;
    end
  end

  assign bus.HEX0        = hex_q[0];
  assign bus.HEX1        = hex_q[1];
  assign bus.HEX2        = hex_q[2];
  assign bus.HEX3        = hex_q[3];
  assign bus.ic_read     = rd_q;
  assign bus.digit_count = cnt_q;
  assign bus.entry_error = err_q;

endmodule
